// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: refill controller for a small set of cache lines.
//
// When every line reports a miss and every line is ready while a cache request
// is pending, the controller latches the line-aligned miss address. It then
// picks the line with the largest miss counter as the victim. The victim gets a
// one-cycle fill pulse, and a flush pulse if it is dirty. The victim owns the
// shared memory bus until it has dropped and then re-raised its ready flag.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   dcache_rdaddr/wraddr, icache_rdaddr, *_req   cache requests
//   line_miss/dirty/ready        per-line status, bit i = line i
//   line_misscnt                 per-line miss counters, MAXMISSBITS each
//   line_flush/fill              one-cycle registered command pulses
//   line_pause                   per-line stall (1 for every non-owner)
//   new_region                   line-aligned region for the fill (registered)
//   line_mem_addr/in/rdreq/wrreq per-line memory requests
//   line_mem_out_valid           read-data valid routed to the owner only
//   mem_addr/in/rdreq/wrreq      shared memory port (0 when nobody owns it)
//   mem_out_valid, mem_busy      shared memory status
//
// Handshake: there is no back-pressure on commands. A fill or flush pulse is a
// single-cycle strobe. The victim acknowledges it by dropping line_ready and
// later raising it again. Requests seen outside IDLE are ignored; the bus owner
// exists only while the acknowledgement is outstanding.
module cache_line_ctrl #(
  parameter int ADDRBITS    = 32,
  parameter int DATABITS    = 32,
  parameter int LSBBITS     = 7,
  parameter int MAXMISSBITS = 8,
  parameter int NLINES      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDRBITS-1:0]           dcache_rdaddr,
  input  logic [ADDRBITS-1:0]           dcache_wraddr,
  input  logic [ADDRBITS-1:0]           icache_rdaddr,
  input  logic                          dcache_rdreq,
  input  logic                          dcache_wrreq,
  input  logic                          icache_rdreq,
  input  logic [NLINES-1:0]             line_miss,
  input  logic [NLINES-1:0]             line_dirty,
  input  logic [NLINES-1:0]             line_ready,
  input  logic [NLINES*MAXMISSBITS-1:0] line_misscnt,
  output logic [NLINES-1:0]             line_flush,
  output logic [NLINES-1:0]             line_fill,
  output logic [NLINES-1:0]             line_pause,
  output logic [ADDRBITS-1:0]           new_region,
  input  logic [NLINES*ADDRBITS-1:0]    line_mem_addr,
  input  logic [NLINES*DATABITS-1:0]    line_mem_in,
  input  logic [NLINES-1:0]             line_mem_rdreq,
  input  logic [NLINES-1:0]             line_mem_wrreq,
  output logic [NLINES-1:0]             line_mem_out_valid,
  output logic [ADDRBITS-1:0]           mem_addr,
  output logic [DATABITS-1:0]           mem_in,
  output logic                          mem_rdreq,
  output logic                          mem_wrreq,
  input  logic                          mem_out_valid,
  input  logic                          mem_busy
);

  localparam int VBITS = (NLINES > 1) ? $clog2(NLINES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    ISSUE      = 3'd2,
    WAIT_DROP  = 3'd3,
    WAIT_READY = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [VBITS-1:0]    victim;
  logic [ADDRBITS-1:0] cap_addr;

  logic                global_miss;
  logic [ADDRBITS-1:0] miss_addr;
  logic [VBITS-1:0]    best_idx;
  logic [MAXMISSBITS-1:0] best_cnt;
  logic [NLINES-1:0]   victim_onehot;
  logic                victim_ready;
  logic                owner_valid;

  assign global_miss = (dcache_rdreq | dcache_wrreq | icache_rdreq) &
                       (&line_miss) & (&line_ready);

  // Writes take priority over reads; the data cache over the instruction cache.
  always_comb begin
    miss_addr = icache_rdaddr;
    if (dcache_wrreq)      miss_addr = dcache_wraddr;
    else if (dcache_rdreq) miss_addr = dcache_rdaddr;
  end

  // Largest miss counter wins. The strict compare keeps ties on the lowest index.
  always_comb begin
    best_idx = '0;
    best_cnt = line_misscnt[0 +: MAXMISSBITS];
    for (int i = 1; i < NLINES; i++) begin
      if (line_misscnt[i*MAXMISSBITS +: MAXMISSBITS] > best_cnt) begin
        best_cnt = line_misscnt[i*MAXMISSBITS +: MAXMISSBITS];
        best_idx = VBITS'(i);
      end
    end
  end

  assign victim_onehot = {{(NLINES-1){1'b0}}, 1'b1} << victim;
  assign victim_ready  = line_ready[victim];
  assign owner_valid   = (state == WAIT_DROP) || (state == WAIT_READY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (global_miss) state_next = SELECT;
      SELECT:     state_next = ISSUE;
      ISSUE:      state_next = WAIT_DROP;
      WAIT_DROP:  if (!victim_ready) state_next = WAIT_READY;
      WAIT_READY: if (victim_ready)  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // The command outputs are registered from the ISSUE state. The pulse therefore
  // appears in the cycle after ISSUE, which is the first WAIT_DROP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      victim     <= '0;
      cap_addr   <= '0;
      line_fill  <= '0;
      line_flush <= '0;
      new_region <= '0;
    end else begin
      if (state == IDLE && global_miss)
        cap_addr <= {miss_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
      if (state == SELECT)
        victim <= best_idx;
      if (state == ISSUE) begin
        line_fill  <= victim_onehot;
        line_flush <= victim_onehot & line_dirty;
        new_region <= cap_addr;
      end else begin
        line_fill  <= '0;
        line_flush <= '0;
      end
    end
  end

  // Shared-bus routing. Only the victim may reach memory, and only while its
  // refill acknowledgement is outstanding. Every other line is held paused.
  always_comb begin
    mem_addr           = '0;
    mem_in             = '0;
    mem_rdreq          = 1'b0;
    mem_wrreq          = 1'b0;
    line_mem_out_valid = '0;
    line_pause         = '1;
    if (owner_valid) begin
      mem_addr                   = line_mem_addr[victim*ADDRBITS +: ADDRBITS];
      mem_in                     = line_mem_in[victim*DATABITS +: DATABITS];
      mem_rdreq                  = line_mem_rdreq[victim];
      mem_wrreq                  = line_mem_wrreq[victim];
      line_mem_out_valid[victim] = mem_out_valid;
      line_pause[victim]         = mem_busy;
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Testbench for cache_line_ctrl.
// The reference model follows each refill as a transaction with an age counted
// in clock edges since capture. Edge 1 picks the victim and edge 2 issues the
// pulse. After that, the victim must drop line_ready and then raise it again.
// The model is compared against the DUT on every falling edge. Directed
// scenarios add literal expectations on top of the model comparison.
module tb_cache_line_ctrl;
  localparam int AW = 32, DW = 32, LSB = 7, MB = 8, NL = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] dcache_rdaddr = '0, dcache_wraddr = '0, icache_rdaddr = '0;
  logic dcache_rdreq = 1'b0, dcache_wrreq = 1'b0, icache_rdreq = 1'b0;
  logic [NL-1:0] line_miss = '0, line_dirty = '0, line_ready = '0;
  logic [NL*MB-1:0] line_misscnt = '0;
  logic [NL-1:0] line_flush, line_fill, line_pause;
  logic [AW-1:0] new_region;
  logic [NL*AW-1:0] line_mem_addr = '0;
  logic [NL*DW-1:0] line_mem_in = '0;
  logic [NL-1:0] line_mem_rdreq = '0, line_mem_wrreq = '0;
  logic [NL-1:0] line_mem_out_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic mem_rdreq, mem_wrreq;
  logic mem_out_valid = 1'b0, mem_busy = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  logic cmp_en = 1'b0;

  cache_line_ctrl #(.ADDRBITS(AW), .DATABITS(DW), .LSBBITS(LSB),
                    .MAXMISSBITS(MB), .NLINES(NL)) dut (
    .clk(clk), .reset_n(reset_n),
    .dcache_rdaddr(dcache_rdaddr), .dcache_wraddr(dcache_wraddr),
    .icache_rdaddr(icache_rdaddr), .dcache_rdreq(dcache_rdreq),
    .dcache_wrreq(dcache_wrreq), .icache_rdreq(icache_rdreq),
    .line_miss(line_miss), .line_dirty(line_dirty), .line_ready(line_ready),
    .line_misscnt(line_misscnt), .line_flush(line_flush), .line_fill(line_fill),
    .line_pause(line_pause), .new_region(new_region),
    .line_mem_addr(line_mem_addr), .line_mem_in(line_mem_in),
    .line_mem_rdreq(line_mem_rdreq), .line_mem_wrreq(line_mem_wrreq),
    .line_mem_out_valid(line_mem_out_valid), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_out_valid(mem_out_valid), .mem_busy(mem_busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int argmax(input logic [NL*MB-1:0] cnt);
    int best = 0;
    for (int i = 1; i < NL; i++)
      if (cnt[i*MB +: MB] > cnt[best*MB +: MB]) best = i;
    return best;
  endfunction

  logic          m_active = 1'b0;
  int            m_age = 0;
  logic          m_dropped = 1'b0;
  int            m_vic = 0;
  logic [AW-1:0] m_addr = '0, m_region = '0;
  logic [NL-1:0] m_fill = '0, m_flush = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_age = 0; m_dropped = 1'b0; m_vic = 0;
      m_addr = '0; m_region = '0; m_fill = '0; m_flush = '0;
    end else begin
      m_fill = '0; m_flush = '0;
      if (!m_active) begin
        if ((dcache_rdreq | dcache_wrreq | icache_rdreq) && line_miss == '1 &&
            line_ready == '1) begin
          m_active = 1'b1; m_age = 0; m_dropped = 1'b0;
          m_addr = dcache_wrreq ? dcache_wraddr : dcache_rdreq ? dcache_rdaddr : icache_rdaddr;
          m_addr = (m_addr >> LSB) << LSB;
        end
      end else begin
        m_age++;
        if (m_age == 1) m_vic = argmax(line_misscnt);
        else if (m_age == 2) begin
          m_fill = NL'(1) << m_vic;
          m_flush = m_fill & line_dirty;
          m_region = m_addr;
        end else if (!m_dropped) begin
          if (!line_ready[m_vic]) m_dropped = 1'b1;
        end else if (line_ready[m_vic]) m_active = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic          e_own;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_min;
  logic          e_rd, e_wr;
  logic [NL-1:0] e_ov, e_pause;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_own   = m_active && m_age >= 2;
      e_maddr = e_own ? line_mem_addr[m_vic*AW +: AW] : '0;
      e_min   = e_own ? line_mem_in[m_vic*DW +: DW] : '0;
      e_rd    = e_own ? line_mem_rdreq[m_vic] : 1'b0;
      e_wr    = e_own ? line_mem_wrreq[m_vic] : 1'b0;
      e_ov    = e_own ? (NL'(mem_out_valid) << m_vic) : '0;
      e_pause = e_own ? ((~(NL'(1) << m_vic)) | (NL'(mem_busy) << m_vic)) : '1;
      n_total++;
      if ({line_fill, line_flush, new_region, mem_addr, mem_in, mem_rdreq, mem_wrreq,
           line_mem_out_valid, line_pause} !==
          {m_fill, m_flush, m_region, e_maddr, e_min, e_rd, e_wr, e_ov, e_pause})
        $display("FAIL model t=%0t: got fill=%h flush=%h region=%h maddr=%h min=%h rd=%b wr=%b ov=%h pause=%h; exp fill=%h flush=%h region=%h maddr=%h min=%h rd=%b wr=%b ov=%h pause=%h",
                 $time, line_fill, line_flush, new_region, mem_addr, mem_in, mem_rdreq,
                 mem_wrreq, line_mem_out_valid, line_pause, m_fill, m_flush, m_region,
                 e_maddr, e_min, e_rd, e_wr, e_ov, e_pause);
      else n_pass++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    dcache_rdreq = 1'b0; dcache_wrreq = 1'b0; icache_rdreq = 1'b0;
  endtask

  // Acknowledge a refill: the victim drops ready for one cycle, then raises it.
  task automatic finish_refill(input int v);
    line_ready = 4'hF;
    line_ready[v] = 1'b0;
    tick();
    line_ready = 4'hF;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    line_miss = 4'hF; line_ready = 4'hF;
    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_fill", line_fill, 0);
    chk("reset_pause", line_pause, 4'hF);
    chk("reset_region", new_region, 0);
    reset_n = 1'b1;
    tick();

    // Model pins: the victim-selection rule on two literal cases.
    chk("argmax_tie", argmax({8'd5, 8'd40, 8'd40, 8'd10}), 1);
    chk("argmax_top", argmax({8'd255, 8'd0, 8'd254, 8'd0}), 3);

    // Clean miss: counts {10,40,40,5}; the tie between lines 1 and 2 goes to line 1.
    line_misscnt = {8'd5, 8'd40, 8'd40, 8'd10};
    line_dirty = 4'h0;
    dcache_rdaddr = 32'h0000_1234; dcache_rdreq = 1'b1;
    tick(); clear_reqs();
    tick(); chk("clean_no_early_fill", line_fill, 0);
    tick();
    chk("clean_fill", line_fill, 4'b0010);
    chk("clean_flush", line_flush, 4'b0000);
    chk("clean_region", new_region, 32'h0000_1200);
    tick(); chk("clean_fill_one_cycle", line_fill, 0);
    finish_refill(1);

    // Dirty victim with write priority.
    line_misscnt = {8'd255, 8'd3, 8'd2, 8'd1};
    line_dirty = 4'b1000;
    dcache_wraddr = 32'h8000_00FC; dcache_wrreq = 1'b1;
    icache_rdaddr = 32'h1111_1111; icache_rdreq = 1'b1;
    tick(); clear_reqs();
    tick(); tick();
    chk("dirty_fill", line_fill, 4'b1000);
    chk("dirty_flush", line_flush, 4'b1000);
    chk("dirty_region", new_region, 32'h8000_0080);
    tick();
    finish_refill(3);

    // Bus routing with owner 2, followed by a request that must be ignored.
    line_misscnt = {8'd0, 8'd99, 8'd0, 8'd0};
    line_dirty = 4'h0;
    dcache_rdreq = 1'b1; dcache_rdaddr = 32'h0000_4000;
    tick(); clear_reqs();
    tick(); tick(); tick();
    line_ready = 4'b1011;
    tick();
    line_mem_addr = {32'hDEAD_0003, 32'h0000_00A0, 32'hDEAD_0001, 32'hDEAD_0000};
    line_mem_rdreq = 4'b1011 | 4'b0100;
    line_mem_rdreq[1] = 1'b0;
    mem_busy = 1'b1;
    #1;
    chk("bus_addr", mem_addr, 32'hA0);
    chk("bus_rdreq", mem_rdreq, 1);
    chk("bus_pause_busy", line_pause, 4'b1111);
    mem_busy = 1'b0; mem_out_valid = 1'b1;
    #1;
    chk("bus_pause_free", line_pause, 4'b1011);
    chk("bus_out_valid", line_mem_out_valid, 4'b0100);
    dcache_rdreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ignored_no_fill", line_fill, 0);
    end
    line_ready = 4'hF;
    tick(); chk("reeval_idle", line_fill, 0);
    tick(); clear_reqs(); chk("reeval_select", line_fill, 0);
    tick(); chk("reeval_issue", line_fill, 0);
    tick(); chk("reeval_fill", line_fill, 4'b0100);
    mem_out_valid = 1'b0;
    tick();
    finish_refill(2);

    // A miss while one line is not ready must not start a refill.
    line_misscnt = '0;
    line_ready = 4'b1110;
    icache_rdreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("notready_no_fill", line_fill, 0);
    end
    line_ready = 4'hF;
    tick(); clear_reqs();
    tick(); chk("notready_gap", line_fill, 0);
    tick(); chk("notready_fill", line_fill, 4'b0001);
    tick();
    finish_refill(0);

    // Reset in the middle of a refill abandons it at once.
    line_misscnt = {8'd0, 8'd0, 8'd7, 8'd0};
    line_mem_rdreq = 4'hF; mem_busy = 1'b1;
    dcache_rdreq = 1'b1;
    tick(); clear_reqs();
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_fill", line_fill, 0);
    chk("rst_region", new_region, 0);
    chk("rst_mem_rdreq", mem_rdreq, 0);
    chk("rst_pause", line_pause, 4'hF);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("rst_no_pulse", line_fill, 0);
    end
    mem_busy = 1'b0; line_mem_rdreq = '0;

    // Randomized traffic, with occasional single-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      dcache_rdreq = ($urandom_range(0, 3) == 0);
      dcache_wrreq = ($urandom_range(0, 5) == 0);
      icache_rdreq = ($urandom_range(0, 3) == 0);
      dcache_rdaddr = $urandom; dcache_wraddr = $urandom; icache_rdaddr = $urandom;
      line_miss  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      line_ready = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      line_dirty = 4'($urandom);
      for (int i = 0; i < NL; i++)
        line_misscnt[i*MB +: MB] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      line_mem_addr = {$urandom, $urandom, $urandom, $urandom};
      line_mem_in = {$urandom, $urandom, $urandom, $urandom};
      line_mem_rdreq = 4'($urandom); line_mem_wrreq = 4'($urandom);
      mem_out_valid = 1'($urandom); mem_busy = 1'($urandom);
      tick();
    end
    reset_n = 1'b1;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
